// File: rtl/muldiv_if.sv
// Handshake bundle between the issue logic and the RV64M multiply/divide unit.
// master: start, funct3, operand_a, operand_b out; busy, done, result in.
interface muldiv_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, operand_a, operand_b,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, operand_a, operand_b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one iteration per clock.
// Ports: clock, reset (async, active-high), bus (muldiv_if.slave).
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic      clock,
    input  logic      reset,
    muldiv_if.slave   bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic              byp_q, byp_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              is_div, sgn_a, sgn_b, neg_a, neg_b;
    logic              b_zero, ovf;
    logic [XLEN-1:0]   mag_a, mag_b, preset;
    logic [XLEN:0]     mul_sum, div_try;
    logic [XLEN-1:0]   div_sub;
    logic              div_ok;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, prod;
    logic [XLEN-1:0]   quo, rem, mul_res, div_res, fin_res;

    always_comb begin
        is_div = bus.funct3[2];
        sgn_a  = bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
        sgn_b  = bus.funct3 inside {3'b001, 3'b100, 3'b110};
        neg_a  = sgn_a & bus.operand_a[XLEN-1];
        neg_b  = sgn_b & bus.operand_b[XLEN-1];
        mag_a  = neg_a ? -bus.operand_a : bus.operand_a;
        mag_b  = neg_b ? -bus.operand_b : bus.operand_b;
        b_zero = bus.operand_b == '0;
        ovf    = ~bus.funct3[0] & (bus.operand_a == MIN)
               & (bus.operand_b == '1);
        if (b_zero)
            preset = bus.funct3[1] ? bus.operand_a : '1;
        else
            preset = bus.funct3[1] ? '0 : MIN;

        // Multiply: acc = {partial, multiplier}; add then shift right.
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
        mul_nxt = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                           : {1'b0, acc_q[2*XLEN-1:1]};

        // Divide: acc = {remainder, dividend/quotient}; shift left, try subtract.
        div_try = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ok  = div_try >= {1'b0, a_q};
        div_sub = div_try[XLEN-1:0] - a_q;
        div_nxt = div_ok ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                         : {div_try[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

        prod    = (sa_q ^ sb_q) ? -acc_q : acc_q;
        mul_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0]
                                       : prod[2*XLEN-1:XLEN];
        quo     = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem     = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        div_res = f3_q[1] ? rem : quo;
        if (byp_q)
            fin_res = acc_q[XLEN-1:0];
        else
            fin_res = f3_q[2] ? div_res : mul_res;
    end

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        byp_d   = byp_q;
        a_d     = a_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    f3_d  = bus.funct3;
                    sa_d  = neg_a;
                    sb_d  = neg_b;
                    cnt_d = '0;
                    if (is_div && (b_zero || ovf)) begin
                        byp_d   = 1'b1;
                        acc_d   = {{XLEN{1'b0}}, preset};
                        state_d = FINISH;
                    end else begin
                        byp_d   = 1'b0;
                        a_d     = is_div ? mag_b : mag_a;
                        acc_d   = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = f3_q[2] ? div_nxt : mul_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1))
                    state_d = FINISH;
            end
            FINISH: begin
                res_d   = fin_res;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            f3_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            byp_q   <= 1'b0;
            a_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            byp_q   <= byp_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign bus.busy   = state_q != IDLE;
    assign bus.done   = done_q;
    assign bus.result = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clock = ~clock;

    muldiv_if #(.XLEN(64)) bus();

    muldiv_unit #(.XLEN(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(logic [2:0] f, logic [63:0] a,
                                          logic [63:0] b);
        logic [127:0] ae, be, p;
        logic         ov;
        ae = (f == 3'd1 || f == 3'd2) ? {{64{a[63]}}, a} : {64'b0, a};
        be = (f == 3'd1) ? {{64{b[63]}}, b} : {64'b0, b};
        p  = ae * be;
        ov = (a == MIN) && (b == ONES);
        case (f)
            3'd0: return p[63:0];
            3'd1, 3'd2, 3'd3: return p[127:64];
            3'd4: begin
                if (b == 0) return ONES;
                if (ov) return MIN;
                return 64'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? ONES : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ov) return 64'd0;
                return 64'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(logic [2:0] f, logic [63:0] a,
                                     logic [63:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == MIN && b == ONES)))
            return 1;
        return 65;
    endfunction

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return ONES;
            2: return MIN;
            3: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called #1 after an edge with busy low; returns #1 after E0.
    task automatic launch(logic [2:0] f, logic [63:0] a, logic [63:0] b);
        bus.start     = 1'b1;
        bus.funct3    = f;
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges until done; flags any cycle before done with busy low.
    task automatic wait_done(output int n, output bit bdrop);
        bit got;
        n = 0;
        got = 0;
        bdrop = 0;
        while (n < 200 && !got) begin
            @(posedge clock);
            #1;
            n++;
            if (bus.done) got = 1;
            else if (!bus.busy) bdrop = 1;
        end
    endtask

    task automatic run_op(string name, logic [2:0] f, logic [63:0] a,
                          logic [63:0] b, logic [63:0] exp, int lat);
        int n;
        bit bd;
        launch(f, a, b);
        wait_done(n, bd);
        chk({name, " result"}, bus.result, exp);
        chk({name, " latency"}, 64'(n), 64'(lat));
        if (bd) chk({name, " busy"}, 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        bit bd;
        int ndone;
        logic [2:0]  f;
        logic [63:0] a, b;

        tbl[0]  = '{3'd0, 64'd7, -64'd3, 64'hFFFF_FFFF_FFFF_FFEB, 65};
        tbl[1]  = '{3'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        tbl[2]  = '{3'd4, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        tbl[3]  = '{3'd6, -64'd7, 64'd2, ONES, 65};
        tbl[4]  = '{3'd5, 64'd100, 64'd7, 64'd14, 65};
        tbl[5]  = '{3'd7, 64'd100, 64'd7, 64'd2, 65};
        tbl[6]  = '{3'd5, 64'h1234, 64'd0, ONES, 1};
        tbl[7]  = '{3'd7, 64'h1234, 64'd0, 64'h1234, 1};
        tbl[8]  = '{3'd4, MIN, ONES, MIN, 1};
        tbl[9]  = '{3'd6, MIN, ONES, 64'd0, 1};
        tbl[10] = '{3'd1, ONES, ONES, 64'd0, 65};
        tbl[11] = '{3'd2, ONES, 64'd2, ONES, 65};
        tbl[12] = '{3'd4, 64'd7, 64'd0, ONES, 1};
        tbl[13] = '{3'd6, -64'd5, 64'd0, -64'd5, 1};

        bus.start     = 1'b0;
        bus.funct3    = 3'd0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset result", bus.result, 64'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        foreach (tbl[i])
            run_op($sformatf("tbl%0d", i), tbl[i].f3, tbl[i].a,
                   tbl[i].b, tbl[i].exp, tbl[i].lat);

        // Ignored start during busy, operand changes after E0.
        launch(3'd5, 64'd100, 64'd7);
        repeat (10) @(posedge clock);
        #1;
        bus.start     = 1'b1;
        bus.funct3    = 3'd0;
        bus.operand_a = 64'd3;
        bus.operand_b = 64'd9;
        @(posedge clock);
        #1;
        bus.start     = 1'b0;
        bus.operand_a = 64'd55;
        wait_done(n, bd);
        chk("ignored start result", bus.result, 64'd14);
        chk("ignored start latency", 64'(n), 64'd54);

        // Back-to-back start in the done cycle.
        chk("done cycle busy", 64'(bus.busy), 64'd0);
        launch(3'd0, 64'd6, 64'd7);
        chk("b2b busy", 64'(bus.busy), 64'd1);
        chk("b2b hold", bus.result, 64'd14);
        wait_done(n, bd);
        chk("b2b result", bus.result, 64'd42);
        chk("b2b latency", 64'(n), 64'd65);
        bus.operand_a = 64'd1;
        repeat (5) @(posedge clock);
        #1;
        chk("idle hold", bus.result, 64'd42);

        // Reset mid-run at iteration 20 of a MUL.
        launch(3'd0, 64'd12345, 64'd678);
        repeat (20) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("abort busy", 64'(bus.busy), 64'd0);
        chk("abort done", 64'(bus.done), 64'd0);
        chk("abort result", bus.result, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        ndone = 0;
        repeat (80) begin
            @(posedge clock);
            #1;
            if (bus.done || bus.busy) ndone++;
        end
        chk("abort no done", 64'(ndone), 64'd0);

        for (int i = 0; i < 150; i++) begin
            f = 3'($urandom_range(0, 7));
            a = rnd_op();
            b = rnd_op();
            run_op($sformatf("rnd%0d f3=%0d a=%h b=%h", i, f, a, b),
                   f, a, b, model(f, a, b), model_lat(f, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule
